// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud-timing helpers.
// Common to the receiver and the transmitter so both derive identical bit timing.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_bit(input int clk_freq, input int baud_rate);
    return clks_per_bit(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte bus from uart_rx (master) to the byte consumer (slave).
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (output rx_byte, rx_valid, frame_err, rx_busy);
  modport slave  (input  rx_byte, rx_valid, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Purpose: 2-flop synchroniser for an async input plus a falling-edge detect flop.
// Latency: rx_s lags rx by 2 clk; fall is combinational from the flops.
// Backpressure: none, free-running.
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver, mid-bit sampling; UART_RX_MAJORITY_EN adds 2-of-3 vote.
// Latency: rx_valid 9.5 bit times + 3 clk after the line falls (+1 clk with the vote).
// Backpressure: none; rx_valid/frame_err are single-cycle pulses the consumer must take.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      rx,
  uart_rx_if.master rx_out
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int IW           = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 8) begin : g_bad_baud
    $error("uart_rx: CLK_FREQ/BAUD_RATE must give at least 8 clocks per bit");
  end

  logic rx_s;
  logic fall;
  logic sample;

  uart_rx_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .rx     (rx),
    .rx_s   (rx_s),
    .fall   (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decision moves to mid+1 so the vote sees mid-1, mid, mid+1; later bits inherit the skew.
  localparam int SKEW = 1;
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (!resetn) hist <= 2'b11;
    else         hist <= {hist[0], rx_s};
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  localparam int SKEW = 0;
  assign sample = rx_s;
`endif

  localparam logic [CW-1:0] START_LAST = CW'(HALF_BIT - 1 + SKEW);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] rx_byte_r;
  logic                 rx_valid_r;
  logic                 frame_err_r;
  logic [1:0]           warm;
  logic                 armed;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_byte_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      warm        <= 2'b00;
      armed       <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      // Synchroniser resets high, so a line still low after reset must be seen high before arming.
      warm        <= {warm[0], 1'b1};
      if (warm[1] && rx_s) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fall && armed) state <= ST_START;
        end

        ST_START: begin
          if (cnt == START_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= sample ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {sample, shift[DATA_BITS-1:1]};
            if (bit_idx == IW'(DATA_BITS - 1)) state <= ST_STOP;
            else                               bit_idx <= bit_idx + IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (sample) begin
              rx_byte_r  <= shift;
              rx_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign rx_out.rx_byte   = rx_byte_r;
  assign rx_out.rx_valid  = rx_valid_r;
  assign rx_out.frame_err = frame_err_r;
  assign rx_out.rx_busy   = (state != ST_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Same frame format and baud derivation as the team's UART transmitter, so the two loop back directly.
- Sits between the asynchronous board RX pin and the internal byte consumer.
- Synchronises the line, finds the start edge, samples each bit at mid-bit, and delivers each byte as a one-cycle valid pulse with framing-error reporting.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate.
- Derived localparam CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide; 10416 at defaults).
- Derived localparam HALF_BIT = CLKS_PER_BIT / 2.
- Elaboration requires CLKS_PER_BIT >= 8.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; synchronous, active-low.
- rx  input  1  asynchronous serial line; idles high.
- rx_byte  output  8  last correctly framed byte; holds until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_byte is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  output  1  high from start-edge detection until the frame ends (stop-bit sample or glitch reject).

Behaviour:
- Reset values (resetn low at a clk edge):
  - rx_byte = 0x00; rx_valid = 0; frame_err = 0; rx_busy = 0.
  - Synchroniser flops = 1; state = IDLE; all counters = 0.
- Synchroniser and edge detect:
  - 2-flop synchroniser on rx produces rx_s.
  - A third flop rx_q gives the start edge: rx_q == 1 and rx_s == 0.
- Bit-timing counter:
  - Width $clog2(CLKS_PER_BIT).
  - Resets to 0 on every state entry.
  - Increments each clk while not in IDLE.
- State machine:
  - IDLE: on start edge -> START; rx_busy rises the same cycle. A line held low, e.g. a break or after a framing error, does not retrigger until it has gone high again.
  - START: when the counter reaches HALF_BIT-1, sample rx_s.
    - rx_s == 0 -> DATA; bit_idx = 0; counter cleared.
    - rx_s == 1 -> glitch; back to IDLE with no output pulse.
  - DATA: every CLKS_PER_BIT-1 counts, sample rx_s and shift it in LSB first (shift = {sample, shift[7:1]}).
    - bit_idx counts 0..7.
    - After the sample at bit_idx 7 -> STOP.
  - STOP: after CLKS_PER_BIT-1 counts, sample rx_s.
    - Sample 1: rx_byte <= shift; rx_valid pulses for one cycle.
    - Sample 0: frame_err pulses for one cycle; rx_byte is unchanged.
    - Either case -> IDLE, and rx_busy falls the same cycle.
- Latency: the rx_valid pulse comes nominally 9.5 bit times after the line falling edge, plus 3 clk of synchroniser/edge delay. Bench tolerance is ±2 clk.
- Back-to-back frames: because STOP exits at mid-stop-bit, the next start edge is accepted with zero idle time between frames.
- rx_valid and frame_err are never high in the same cycle.
- Reset mid-frame: aborts immediately, with no pulse on rx_valid or frame_err. The remaining bits of the interrupted frame are ignored until a fresh start edge arrives after the line returns high.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every mid-bit sample (start, data, stop) is the 2-of-3 majority of rx_s at counter values mid-1, mid, mid+1.
  - The decision is taken at mid+1, which adds 1 clk to the rx_valid latency.
  - A single-clock noise spike on any bit is rejected.
- Undefined: single sample at mid-bit, exactly as described in Behaviour.

Decomposition:
- Shared package uart_pkg holds:
  - The state encoding (IDLE, START, DATA, STOP).
  - The CLKS_PER_BIT / HALF_BIT calculation as a constant function shared with the transmitter.
  - Constant DATA_BITS = 8.
- One natural sub-module, uart_rx_sync: 2-flop synchroniser plus edge-detect flop.
  - Ports: clk, resetn, rx -> rx_s, fall.
  - Reset value 1 on all flops.
  - Reusable by other async inputs.

Test Plan (bench uses CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10):
- Loopback through the transmitter sending 0xA5 -> exactly one rx_valid pulse with rx_byte=0xA5; frame_err stays 0.
- Three back-to-back frames 0x00, 0xFF, 0x3C with zero idle gap -> three rx_valid pulses in order with matching rx_byte; none dropped.
- rx driven low for 3 clk, then high -> rx_busy pulses high, then returns low at the START sample; no rx_valid and no frame_err.
- Frame for 0x55 with stop bit forced low -> frame_err pulses once; rx_valid stays 0; rx_byte keeps its previous value. The line is then held low for 30 clk and released -> no new frame starts until rx goes high.
- resetn asserted during data bit 4 of 0x81 -> all outputs at reset values the next cycle; no pulse. A following clean 0x81 frame is received correctly.
- With UART_RX_MAJORITY_EN defined: a 1-clk inverted spike at the mid-bit of data bit 2 of 0x00 -> rx_byte=0x00. Without the macro the same stimulus gives rx_byte=0x04.
